// File: rtl/menu_overlay_ctrl.sv
// Menu BRAM port-B sequencer: prefetches text code and glyph row one cell ahead
// of the overlay pixel stream and slots host read/write accesses into idle cycles.
`timescale 1ns/1ps
module menu_overlay_ctrl #(
  parameter logic [10:0] FONT_BASE = 11'h400,
  parameter int          TEXT_ROWS = 28
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        menu_en,
  input  logic        line_start,
  input  logic [7:0]  ovl_y,
  input  logic        pix_ce,
  input  logic [7:0]  ovl_x,
  output logic        ovl_pixel,
  output logic        ovl_valid,
  output logic        ovl_underrun,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [10:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_ack,
  output logic [10:0] bram_ad,
  output logic [7:0]  bram_din,
  output logic        bram_ce,
  output logic        bram_wre,
  input  logic [7:0]  bram_dout
);

  localparam logic [7:0] Y_LIMIT = 8'(TEXT_ROWS * 8);

  typedef enum logic [2:0] {
    IDLE, CHR_RD, CHR_WT, FNT_RD, FNT_WT, HOST, HOST_WT
  } state_e;

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic [4:0] col_q, col_d;
  logic [7:0] line_y_q, line_y_d;
  logic [7:0] code_q, code_d;
  logic [7:0] next_buf_q, next_buf_d;
  logic       next_inv_q, next_inv_d;
  logic [7:0] cur_byte_q, cur_byte_d;
  logic       cur_inv_q, cur_inv_d;
  logic       pixel_q, pixel_d;
  logic       valid_q, valid_d;
  logic       underrun_q, underrun_d;
  logic [7:0] rdata_q, rdata_d;

  logic       cell_edge, trig_cell, trig_any, new_fetch, y_visible, fetch_busy;
  logic [4:0] cell_col, new_col;
  logic [7:0] src_byte;
  logic       src_inv;
  state_e     restart_state;

  // line_start wins over a coincident pix_ce, which is then ignored entirely.
  assign cell_edge  = (ovl_x[2:0] == 3'd0);
  assign cell_col   = ovl_x[7:3];
  assign trig_cell  = pix_ce & ~line_start & cell_edge;
  assign trig_any   = line_start | trig_cell;
  assign y_visible  = (line_y_q < Y_LIMIT);
  assign new_fetch  = line_start ? (ovl_y < Y_LIMIT) : ((cell_col != 5'd31) & y_visible);
  assign new_col    = line_start ? 5'd0 : 5'(cell_col + 5'd1);
  assign fetch_busy = pending_q | (state_q == CHR_RD) | (state_q == CHR_WT) |
                      (state_q == FNT_RD) | (state_q == FNT_WT);
  assign restart_state = new_fetch ? CHR_RD : (host_req ? HOST : IDLE);

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    col_d      = col_q;
    line_y_d   = line_y_q;
    code_d     = code_q;
    next_buf_d = next_buf_q;
    next_inv_d = next_inv_q;
    cur_byte_d = cur_byte_q;
    cur_inv_d  = cur_inv_q;
    pixel_d    = pixel_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q;
    rdata_d    = rdata_q;
    src_byte   = cur_byte_q;
    src_inv    = cur_inv_q;
    bram_ad    = 11'h000;
    bram_din   = 8'h00;
    bram_ce    = 1'b0;
    bram_wre   = 1'b0;
    host_ack   = 1'b0;
    host_rdata = rdata_q;

    if (line_start) line_y_d = ovl_y;
    if (trig_any && new_fetch) col_d = new_col;

    if (pix_ce && !line_start) begin
      valid_d = 1'b1;
      if (cell_edge) begin
        src_byte = next_buf_q;
        src_inv  = next_inv_q;
      end
      pixel_d = (src_byte[ovl_x[2:0]] ^ src_inv) & menu_en & y_visible;
    end

    // A boundary that finds the next cell unfinished keeps the stale buffer.
    if (trig_cell) begin
      cur_byte_d = next_buf_q;
      cur_inv_d  = next_inv_q;
      if (fetch_busy) underrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (trig_any)       state_d = restart_state;
        else if (pending_q) state_d = CHR_RD;
        else if (host_req)  state_d = HOST;
      end
      CHR_RD: begin
        bram_ce = 1'b1;
        bram_ad = {1'b0, line_y_q[7:3], col_q};
        state_d = trig_any ? restart_state : CHR_WT;
      end
      CHR_WT: begin
        code_d  = bram_dout;
        state_d = trig_any ? restart_state : FNT_RD;
      end
      FNT_RD: begin
        bram_ce = 1'b1;
        bram_ad = FONT_BASE + {1'b0, code_q[6:0], line_y_q[2:0]};
        state_d = trig_any ? restart_state : FNT_WT;
      end
      FNT_WT: begin
        if (trig_any) begin
          state_d = restart_state;
        end else begin
          next_buf_d = bram_dout;
          next_inv_d = code_q[7];
          state_d    = host_req ? HOST : IDLE;
        end
      end
      HOST: begin
        bram_ce  = 1'b1;
        bram_wre = host_we;
        bram_ad  = host_addr;
        bram_din = host_wdata;
        host_ack = host_we;
        if (trig_any) pending_d = new_fetch;
        state_d = host_we ? IDLE : HOST_WT;
      end
      HOST_WT: begin
        host_ack   = 1'b1;
        host_rdata = bram_dout;
        rdata_d    = bram_dout;
        if (trig_any) pending_d = new_fetch;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      col_q      <= 5'd0;
      line_y_q   <= 8'd0;
      code_q     <= 8'h00;
      next_buf_q <= 8'h00;
      next_inv_q <= 1'b0;
      cur_byte_q <= 8'h00;
      cur_inv_q  <= 1'b0;
      pixel_q    <= 1'b0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      col_q      <= col_d;
      line_y_q   <= line_y_d;
      code_q     <= code_d;
      next_buf_q <= next_buf_d;
      next_inv_q <= next_inv_d;
      cur_byte_q <= cur_byte_d;
      cur_inv_q  <= cur_inv_d;
      pixel_q    <= pixel_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      rdata_q    <= rdata_d;
    end
  end

  assign ovl_pixel    = pixel_q;
  assign ovl_valid    = valid_q;
  assign ovl_underrun = underrun_q;

endmodule

// File: tb/tb_menu_overlay_ctrl.sv
// Bench for menu_overlay_ctrl: BRAM model behind port B, table-driven line renders
// plus directed sequences for arbitration, reset mid-transaction and underrun.
`timescale 1ns/1ps
module tb_menu_overlay_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        menu_en = 1'b0;
  logic        line_start = 1'b0;
  logic [7:0]  ovl_y = 8'd0;
  logic        pix_ce = 1'b0;
  logic [7:0]  ovl_x = 8'd0;
  logic        ovl_pixel, ovl_valid, ovl_underrun;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [10:0] host_addr = 11'h000;
  logic [7:0]  host_wdata = 8'h00;
  logic [7:0]  host_rdata;
  logic        host_ack;
  logic [10:0] bram_ad;
  logic [7:0]  bram_din;
  logic        bram_ce, bram_wre;
  logic [7:0]  bram_dout = 8'h00;

  always #5 clk = ~clk;

  menu_overlay_ctrl dut (
    .clk(clk), .resetn(resetn), .menu_en(menu_en), .line_start(line_start),
    .ovl_y(ovl_y), .pix_ce(pix_ce), .ovl_x(ovl_x), .ovl_pixel(ovl_pixel),
    .ovl_valid(ovl_valid), .ovl_underrun(ovl_underrun), .host_req(host_req),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack), .bram_ad(bram_ad),
    .bram_din(bram_din), .bram_ce(bram_ce), .bram_wre(bram_wre), .bram_dout(bram_dout)
  );

  logic [7:0] mem [0:2047] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bram_ce) begin
      if (bram_wre) mem[bram_ad] <= bram_din;
      else          bram_dout    <= mem[bram_ad];
    end
  end

  int          compared = 0;
  int          mismatched = 0;
  logic        monOn = 1'b0;
  logic        monClear = 1'b0;
  logic [10:0] watchText = 11'h000;
  logic [10:0] watchFont = 11'h000;
  int          readCount = 0;
  int          validCount = 0;
  logic        sawText = 1'b0;
  logic        sawFont = 1'b0;
  logic [255:0] pixLine;

  // Port-B read and ovl_valid activity observed while a line renders.
  always @(negedge clk) begin
    if (monClear) begin
      readCount  <= 0;
      validCount <= 0;
      sawText    <= 1'b0;
      sawFont    <= 1'b0;
    end else if (monOn) begin
      if (bram_ce && !bram_wre) begin
        readCount <= readCount + 1;
        if (bram_ad == watchText) sawText <= 1'b1;
        if (bram_ad == watchFont) sawFont <= 1'b1;
      end
      if (ovl_valid) validCount <= validCount + 1;
    end
  end

  typedef struct {
    string       name;
    logic [10:0] textAddr;
    logic [7:0]  code;
    logic [7:0]  y;
    logic        en;
    logic [10:0] fontAddr;
    logic [7:0]  expPix;
    int          expReads;
    logic        expText;
    logic        expFont;
  } vecT;

  vecT vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic hostAccess(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                            output logic acked, output logic [7:0] rdata);
    acked = 1'b0;
    rdata = 8'h00;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (host_ack) begin
        acked = 1'b1;
        rdata = host_rdata;
      end
      @(posedge clk); #1;
    end
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic applyStimulus(input vecT v);
    logic       ack;
    logic [7:0] rd;
    int         base;
    hostAccess(1'b1, v.textAddr, v.code, ack, rd);
    checkOutput($sformatf("%s/wrAck", v.name), 32'(ack), 32'd1);
    menu_en = v.en;
    watchText = v.textAddr;
    watchFont = v.fontAddr;
    monClear = 1'b1; @(posedge clk); #1; monClear = 1'b0; monOn = 1'b1;
    line_start = 1'b1; ovl_y = v.y; @(posedge clk); #1; line_start = 1'b0;
    repeat (6) @(posedge clk); #1;
    pixLine = '0;
    for (int x = 0; x < 256; x++) begin
      ovl_x = 8'(x); pix_ce = 1'b1;
      @(posedge clk); #1; pix_ce = 1'b0;
      @(negedge clk);
      if (ovl_valid) pixLine[x] = ovl_pixel;
      repeat (3) @(posedge clk); #1;
    end
    repeat (4) @(posedge clk); #1;
    monOn = 1'b0;
    base = int'(v.textAddr[4:0]) * 8;
    checkOutput($sformatf("%s/pixels", v.name), 32'(pixLine[base +: 8]), 32'(v.expPix));
    checkOutput($sformatf("%s/validCount", v.name), 32'(validCount), 32'd256);
    checkOutput($sformatf("%s/reads", v.name), 32'(readCount), 32'(v.expReads));
    checkOutput($sformatf("%s/textAddr", v.name), 32'(sawText), 32'(v.expText));
    checkOutput($sformatf("%s/fontAddr", v.name), 32'(sawFont), 32'(v.expFont));
    checkOutput($sformatf("%s/underrun", v.name), 32'(ovl_underrun), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        ack, ackSeen;
    logic [7:0]  rd;
    logic [10:0] firstAd;
    int          hostIssue, ackCyc;

    // Pixel bit 0 is leftmost; glyph rows chosen so the expected patterns are asymmetric.
    vecs[0] = '{"charA",      11'h000, 8'h41, 8'd0,   1'b1, 11'h608, 8'h0C, 64, 1'b1, 1'b1};
    vecs[1] = '{"inverse",    11'h000, 8'hC1, 8'd0,   1'b1, 11'h608, 8'hF3, 64, 1'b1, 1'b1};
    vecs[2] = '{"lastCell",   11'h37F, 8'h46, 8'd223, 1'b1, 11'h637, 8'h0F, 64, 1'b1, 1'b1};
    vecs[3] = '{"row1Col5",   11'h025, 8'h41, 8'd13,  1'b1, 11'h60D, 8'h81, 64, 1'b1, 1'b1};
    vecs[4] = '{"disabled",   11'h000, 8'h41, 8'd0,   1'b0, 11'h608, 8'h00, 64, 1'b1, 1'b1};
    vecs[5] = '{"outOfRange", 11'h000, 8'h41, 8'd224, 1'b1, 11'h608, 8'h00, 0,  1'b0, 1'b0};

    repeat (3) @(posedge clk); #1;
    checkOutput("resetCtrl", 32'({ovl_pixel, ovl_valid, ovl_underrun, host_ack,
                                  bram_ce, bram_wre, host_rdata}), 32'd0);
    checkOutput("resetBus", 32'({bram_ad, bram_din}), 32'd0);
    resetn = 1'b1;
    repeat (2) @(posedge clk); #1;

    hostAccess(1'b1, 11'h608, 8'h0C, ack, rd);
    checkOutput("fontWr0", 32'(ack), 32'd1);
    hostAccess(1'b1, 11'h60D, 8'h81, ack, rd);
    checkOutput("fontWr1", 32'(ack), 32'd1);
    hostAccess(1'b1, 11'h637, 8'h0F, ack, rd);
    checkOutput("fontWr2", 32'(ack), 32'd1);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

    // Host read raised together with a cell-boundary fetch trigger.
    menu_en = 1'b1;
    line_start = 1'b1; ovl_y = 8'd0; @(posedge clk); #1; line_start = 1'b0;
    repeat (8) @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h500; pix_ce = 1'b1; ovl_x = 8'd0;
    firstAd = 11'h000; hostIssue = -1; ackCyc = -1; rd = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) firstAd = bram_ce ? bram_ad : 11'h7FF;
      if (bram_ce && bram_ad == 11'h500 && hostIssue < 0) hostIssue = k;
      if (host_ack && ackCyc < 0) begin
        ackCyc = k;
        rd = host_rdata;
      end
      @(posedge clk); #1;
      pix_ce = 1'b0;
      if (ackCyc >= 0) host_req = 1'b0;
    end
    host_req = 1'b0;
    checkOutput("arbFetchFirst", 32'(firstAd), 32'h001);
    checkOutput("arbHostIssue", 32'(hostIssue), 32'd5);
    checkOutput("arbAckWithin6", 32'(ackCyc >= 1 && ackCyc <= 6), 32'd1);
    checkOutput("arbReadData", 32'(rd), 32'h00);

    // Reset asserted while a host read sits in its data-return cycle.
    repeat (10) @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'h005;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hostWtIssue", 32'({bram_ce, bram_ad}), 32'({1'b1, 11'h005}));
    @(posedge clk); #1;
    resetn = 1'b0; #1;
    checkOutput("rstCtrl", 32'({ovl_pixel, ovl_valid, ovl_underrun, host_ack,
                                bram_ce, bram_wre, host_rdata}), 32'd0);
    checkOutput("rstBus", 32'({bram_ad, bram_din}), 32'd0);
    host_req = 1'b0;
    ackSeen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (host_ack) ackSeen = 1'b1;
    end
    @(posedge clk); #1; resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (host_ack) ackSeen = 1'b1;
    end
    checkOutput("rstNoAck", 32'(ackSeen), 32'd0);

    // Two cell boundaries one clock apart: second lands mid-fetch.
    @(posedge clk); #1;
    ovl_x = 8'd0; pix_ce = 1'b1;
    @(posedge clk); #1;
    ovl_x = 8'd8; pix_ce = 1'b1;
    @(negedge clk);
    checkOutput("underrunClear", 32'(ovl_underrun), 32'd0);
    checkOutput("underrunValid", 32'(ovl_valid), 32'd1);
    @(posedge clk); #1; pix_ce = 1'b0;
    @(negedge clk);
    checkOutput("underrunSet", 32'(ovl_underrun), 32'd1);
    repeat (20) @(posedge clk); #1;
    line_start = 1'b1; ovl_y = 8'd8; @(posedge clk); #1; line_start = 1'b0;
    repeat (40) @(posedge clk); #1;
    @(negedge clk);
    checkOutput("underrunSticky", 32'(ovl_underrun), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0; #1;
    checkOutput("underrunReset", 32'(ovl_underrun), 32'd0);
    @(posedge clk); #1; resetn = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
